dmem_byte_controller: RTL and testbench
=======================================

Name: dmem_byte_controller

Overview:
- Sequences 32-bit load/store requests from the MEM stage onto a byte-wide, synchronous-read data SRAM (512 bytes, mapped at 1024).
- Each word access is split into four byte cycles, in big-endian order.
- Asserts `ready` to release the pipeline stall when the access completes.
- Flags out-of-range addresses instead of touching memory.

Parameters:
- BASE_ADR, 1024: first byte address of data memory.
- MEM_BYTES, 512: memory size in bytes.
- AW, 9: SRAM byte-address width, log2(MEM_BYTES).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN  in  1  load request from MEM stage.
- MEM_W_EN  in  1  store request from MEM stage.
- adr  in  32  byte address from ALU; bits [1:0] ignored.
- data_in  in  32  store data.
- ready  out  1  one-cycle pulse: access complete.
- DATA  out  32  load result; valid when ready=1, held until next load completes.
- err  out  1  with ready: address out of range.
- sram_adr  out  AW  byte address to SRAM.
- sram_wdata  out  8  byte write data.
- sram_we  out  1  byte write strobe.
- sram_rdata  in  8  SRAM read data, valid 1 cycle after sram_adr.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, cnt=0.
  - ready=0, err=0, DATA=0, sram_we=0, sram_adr=0, sram_wdata=0.
  - rst overrides any in-flight access; the word may be partially written (bytes already strobed stay written).
- Address decode:
  - aligned = {adr[31:2],2'b0}.
  - off = aligned - BASE_ADR (32-bit unsigned).
  - in_range = (aligned >= BASE_ADR) && (off < MEM_BYTES).
- Byte order: byte k (k=0..3) at off+k maps to word bits [31-8k : 24-8k].
- States: IDLE, WR, RD, DONE.
- IDLE (cycle T0 = cycle request sampled):
  - If MEM_R_EN, latch off and in_range. Read has priority if both enables are high.
  - Else if MEM_W_EN, latch off, data_in and in_range.
  - If !in_range, go to DONE with err=1.
  - Else go to RD or WR with cnt=0.
  - With no request, stay in IDLE.
- WR (T1..T4):
  - sram_we=1, sram_adr=off+cnt, sram_wdata=byte cnt of latched data.
  - cnt increments each cycle; after cnt=3, go to DONE.
- RD (T1..T5):
  - For cnt 0..3: sram_adr=off+cnt, sram_we=0.
  - For cnt 1..4: capture sram_rdata into byte cnt-1 of a shift/assemble register.
  - After cnt=4, go to DONE.
- DONE:
  - ready=1 for exactly one cycle.
  - After a read: DATA = assembled word; if err, DATA = 0.
  - After a write: DATA unchanged.
  - err = latched !in_range.
  - Next state is IDLE.
- Latency, T0 to ready:
  - In-range store: 5 cycles (ready in T5).
  - In-range load: 6 cycles (ready in T6).
  - Out of range: 1 cycle (ready in T1).
- Stall rule: the pipeline stalls while (MEM_R_EN|MEM_W_EN) && !ready.
  - Requests are ignored outside IDLE.
  - A request still asserted in the IDLE cycle after DONE is treated as a new access.
- sram_we is combinational from the state register and is never high outside WR.
- sram_adr never exceeds MEM_BYTES-1 for in-range accesses. The top word (off=508) reaches 511 without wrap.
- Enables dropped mid-access do not abort it; the access completes.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, WR, RD, DONE, 2-bit);
  - BASE_ADR and MEM_BYTES constants;
  - byte-lane extract function.
- One natural sub-module: byte_sram (512x8, synchronous write, registered read). It sits beside the controller in the MEM stage and is used directly by the bench.

Test Plan:
- rst held 2 cycles, then released -> ready=0, sram_we=0, DATA=0, state IDLE.
- Store adr=1026, data_in=0xA1B2C3D4 -> sram bytes 0..3 = A1,B2,C3,D4; sram_we high exactly T1..T4; ready pulse at T5; err=0.
- Load adr=1024 after the store above -> DATA=0xA1B2C3D4 with ready at T6; stall for 6 cycles.
- Load and store both requested at adr=1532 (off=508) -> read performed, sram_adr 508..511, no write strobe.
- Load adr=1020 and store adr=1536 -> ready in T1, err=1, DATA=0 for the load, no sram_we.
- rst asserted at T2 of a store to 1040 -> bytes 1040 and 1041 written, 1042 and 1043 untouched; the next cycle shows IDLE, sram_we=0, and no ready pulse.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data memory path: the controller
// state encoding, the memory map constants and the big-endian byte-lane
// helper used to serialise a 32-bit word onto the byte-wide SRAM.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Controller states; 2 bits cover all four.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Data memory lives at byte address 1024 and is 512 bytes long.
  localparam int unsigned DMEM_BASE_ADR  = 1024;
  localparam int unsigned DMEM_MEM_BYTES = 512;

  // Big-endian lane select: lane 0 is the most significant byte, so the
  // byte at off+k carries word bits [31-8k : 24-8k].
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_sram.sv
// -----------------------------------------------------------------------------
// byte_sram
// 2**AW x 8 data SRAM with synchronous write and registered read. Read data
// for the address presented in one cycle appears in the next cycle; a write
// to the addressed byte returns the old contents on that read.
//
// Ports:
//   clk_i    system clock
//   we_i     byte write strobe
//   adr_i    byte address
//   wdata_i  byte write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module byte_sram #(
  parameter int unsigned AW = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [0:(2**AW)-1];

  // Storage array: write on strobe, always register the addressed byte.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[adr_i] <= wdata_i;
    end
    rdata_o <= mem[adr_i];
  end

endmodule

// File: rtl/dmem_byte_controller.sv
// -----------------------------------------------------------------------------
// dmem_byte_controller
// Turns 32-bit MEM-stage loads/stores into four byte cycles on a byte-wide
// synchronous-read SRAM (big-endian), pulses ready when the word is done and
// flags addresses outside the data memory window with err instead of
// touching memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN  load / store request (load wins if both high)
//   adr, data_in        byte address (bits [1:0] ignored), store data
//   ready, err, DATA    completion pulse, out-of-range flag, load result
//   sram_adr, sram_we,
//   sram_wdata          byte SRAM command
//   sram_rdata          byte SRAM read data (one cycle after sram_adr)
// -----------------------------------------------------------------------------
module dmem_byte_controller
  import dmem_pkg::*;
#(
  parameter int unsigned BASE_ADR  = DMEM_BASE_ADR,
  parameter int unsigned MEM_BYTES = DMEM_MEM_BYTES,
  parameter int unsigned AW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_R_EN,
  input  logic          MEM_W_EN,
  input  logic [31:0]   adr,
  input  logic [31:0]   data_in,
  output logic          ready,
  output logic [31:0]   DATA,
  output logic          err,
  output logic [AW-1:0] sram_adr,
  output logic [7:0]    sram_wdata,
  output logic          sram_we,
  input  logic [7:0]    sram_rdata
);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic [31:0]   aligned;
  logic [31:0]   off_full;
  logic          in_range;

  // Word-align the request and test it against the memory window. The
  // subtraction is unsigned, so addresses below the base wrap to huge
  // offsets; the explicit lower-bound test keeps that unambiguous.
  always_comb begin
    aligned  = adr & ~32'h3;
    off_full = aligned - 32'(BASE_ADR);
    in_range = (aligned >= 32'(BASE_ADR)) && (off_full < 32'(MEM_BYTES));
  end

  // Next-state logic. A read captures the byte returned for the previous
  // cycle's address, so capture lags addressing by one cycle and the read
  // needs a fifth cycle (cnt=4) to collect the last byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (MEM_R_EN || MEM_W_EN) begin
          off_d = off_full[AW-1:0];
          err_d = !in_range;
          cnt_d = 3'd0;
          if (!MEM_R_EN) begin
            wdata_d = data_in;
          end
          if (!in_range) begin
            state_d = DONE;
            if (MEM_R_EN) begin
              data_d = 32'h0;
            end
          end else begin
            state_d = MEM_R_EN ? RD : WR;
          end
        end
      end
      WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = DONE;
        end
      end
      RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) begin
          asm_d = {asm_q[23:0], sram_rdata};
        end
        if (cnt_q == 3'd4) begin
          state_d = DONE;
          data_d  = {asm_q[23:0], sram_rdata};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      off_q   <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // SRAM command and pipeline handshake, decoded straight from the state
  // register so the write strobe can never leak outside WR.
  always_comb begin
    sram_we    = (state_q == WR);
    sram_adr   = '0;
    sram_wdata = 8'h0;
    if ((state_q == WR) || ((state_q == RD) && (cnt_q < 3'd4))) begin
      sram_adr = off_q + AW'(cnt_q);
    end
    if (state_q == WR) begin
      sram_wdata = byte_lane(wdata_q, cnt_q[1:0]);
    end
    ready = (state_q == DONE);
    err   = (state_q == DONE) && err_q;
    DATA  = data_q;
  end

endmodule

// File: tb/tb_dmem_byte_controller.sv
// -----------------------------------------------------------------------------
// tb_dmem_byte_controller
// Drives directed load/store vectors into dmem_byte_controller wired to a
// byte_sram. Each request pushes its expected response onto a queue; a
// monitor on the falling edge checks the SRAM command cycle by cycle and
// pops/compares whenever ready is seen.
// -----------------------------------------------------------------------------
module tb_dmem_byte_controller;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] adr;
  logic [31:0] data_in;
  logic        ready;
  logic [31:0] DATA;
  logic        err;
  logic [8:0]  sram_adr;
  logic [7:0]  sram_wdata;
  logic        sram_we;
  logic [7:0]  sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          start;
    int          lat;
    logic        isWrite;
    logic        inRange;
    logic [8:0]  off;
    logic [31:0] wd;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] lastData = 32'h0;

  dmem_byte_controller #(
    .BASE_ADR (1024),
    .MEM_BYTES(512),
    .AW       (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .adr       (adr),
    .data_in   (data_in),
    .ready     (ready),
    .DATA      (DATA),
    .err       (err),
    .sram_adr  (sram_adr),
    .sram_wdata(sram_wdata),
    .sram_we   (sram_we),
    .sram_rdata(sram_rdata)
  );

  byte_sram #(.AW(9)) u_sram (
    .clk_i  (clk),
    .we_i   (sram_we),
    .adr_i  (sram_adr),
    .wdata_i(sram_wdata),
    .rdata_o(sram_rdata)
  );

  // Free-running clock and a cycle counter stepped on every rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single comparison point: counts every check, reports each miss.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Issue one request, push its expected response, then hold the enables
  // (as a stalled pipeline would) until ready, bounded by a cycle budget.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expData, input logic expErr,
                               input logic [8:0] expOff);
    exp_t e;
    bit   seen;
    @(negedge clk);
    MEM_R_EN = r;
    MEM_W_EN = w;
    adr      = a;
    data_in  = d;
    e.data    = expData;
    e.err     = expErr;
    e.start   = cyc;
    e.isWrite = !r && w;
    e.inRange = !expErr;
    e.off     = expOff;
    e.wd      = d;
    e.lat     = expErr ? 1 : (e.isWrite ? 5 : 6);
    expQ.push_back(e);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    if (!seen) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
  endtask

  // Monitor: checks the SRAM command of the access in flight each cycle and
  // scores the response whenever ready is presented.
  always @(negedge clk) begin
    exp_t        e;
    int          rel;
    logic [31:0] sh;
    if (!rst && expQ.size() > 0) begin
      e   = expQ[0];
      rel = cyc - e.start;
      if (e.inRange && rel >= 1 && rel <= 4) begin
        checkOutput("sram_adr", 32'(sram_adr), 32'(e.off + 9'(rel - 1)));
        checkOutput("sram_we", 32'(sram_we), 32'(e.isWrite));
        if (e.isWrite) begin
          sh = e.wd >> (8 * (4 - rel));
          checkOutput("sram_wdata", 32'(sram_wdata), 32'(sh[7:0]));
        end
      end else begin
        checkOutput("sram_we_idle", 32'(sram_we), 32'd0);
      end
    end
    if (ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("DATA", DATA, e.data);
        checkOutput("err", 32'(err), 32'(e.err));
        checkOutput("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    adr      = 32'h0;
    data_in  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_we", 32'(sram_we), 32'd0);
    checkOutput("rst_DATA", DATA, 32'h0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_adr", 32'(sram_adr), 32'd0);

    // Store, then load it back (off 0).
    applyStimulus(1'b0, 1'b1, 32'd1026, 32'hA1B2C3D4, 32'h0, 1'b0, 9'd0);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 32'hA1B2C3D4, 1'b0, 9'd0);
    // Top word: store, then both enables (read wins), then reload.
    applyStimulus(1'b0, 1'b1, 32'd1532, 32'hDEADBEEF, 32'hA1B2C3D4, 1'b0, 9'd508);
    applyStimulus(1'b1, 1'b1, 32'd1532, 32'h01020304, 32'hDEADBEEF, 1'b0, 9'd508);
    applyStimulus(1'b1, 1'b0, 32'd1532, 32'h0, 32'hDEADBEEF, 1'b0, 9'd508);
    // Out of range on both sides of the window.
    applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b1, 9'd0);
    applyStimulus(1'b0, 1'b1, 32'd1536, 32'h55555555, 32'h0, 1'b1, 9'd0);
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 9'd0);
    // Seed 1040 before interrupting a store to it.
    applyStimulus(1'b0, 1'b1, 32'd1040, 32'h11223344, 32'h0, 1'b0, 9'd16);

    // Reset during T2 of a store: bytes 16 and 17 land, 18 and 19 do not.
    @(negedge clk);
    MEM_W_EN = 1'b1;
    adr      = 32'd1040;
    data_in  = 32'hAABBCCDD;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(ready), 32'd0);
    checkOutput("midrst_we", 32'(sram_we), 32'd0);
    checkOutput("midrst_DATA", DATA, 32'h0);
    rst = 1'b0;
    lastData = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 32'hAABB3344, 1'b0, 9'd16);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
